// File: rtl/region_bin_frame_ctrl_if.sv
// Pixel-timing, config and status bundle for the binarization frame controller.
interface region_bin_frame_ctrl_if #(
  parameter int CNT_W  = 12,
  parameter int COEF_W = 20
);
  logic              pre_img_vsync;
  logic              pre_img_hsync;
  logic              pre_img_valid;
  logic              cfg_wr;
  logic [1:0]        cfg_addr;
  logic [COEF_W-1:0] cfg_wdata;
  logic [COEF_W-1:0] coef;
  logic              bypass;
  logic              img_gate;
  logic              frame_busy;
  logic              frame_done;
  logic [CNT_W-1:0]  meas_width;
  logic [CNT_W-1:0]  meas_height;
  logic              timing_err;
  logic [15:0]       frame_cnt;

  modport slave (
    input  pre_img_vsync, pre_img_hsync, pre_img_valid, cfg_wr, cfg_addr, cfg_wdata,
    output coef, bypass, img_gate, frame_busy, frame_done,
           meas_width, meas_height, timing_err, frame_cnt
  );

  modport master (
    output pre_img_vsync, pre_img_hsync, pre_img_valid, cfg_wr, cfg_addr, cfg_wdata,
    input  coef, bypass, img_gate, frame_busy, frame_done,
           meas_width, meas_height, timing_err, frame_cnt
  );
endinterface

// File: rtl/region_bin_frame_ctrl.sv
// Frame sequencer for the 5x5 local-mean binarizer: arms on a clean vsync rise,
// commits shadow config only at frame boundaries, measures geometry.
module region_bin_frame_ctrl #(
  parameter int CNT_W     = 12,
  parameter int COEF_W    = 20,
  parameter int DEF_COEF  = 603980,
  parameter int DRAIN_CYC = 8
) (
  input logic                 clk,
  input logic                 rst,
  region_bin_frame_ctrl_if.slave bus
);
  localparam int DW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic vs1, vs2, hs1, hs2, val1;
  logic vs_rise, vs_fall, hs_fall;
  logic [DW-1:0] drain_cnt;
  logic drain_zero;

  logic              sh_en, sh_byp;
  logic [COEF_W-1:0] sh_coef, coef_r;
  logic              byp_r, done_r, err_r;
  logic [CNT_W-1:0]  col, row, ref_width, col_eff, mw_r, mh_r;
  logic              first_line;
  logic [15:0]       fcnt_r;

  logic gate, commit, frame_start, frame_end, line_end, line_cnt, width_bad;

  // Registered copy of stream timing; edges compare stage 1 against stage 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs1 <= 1'b0; vs2 <= 1'b0; hs1 <= 1'b0; hs2 <= 1'b0; val1 <= 1'b0;
    end else begin
      vs1 <= bus.pre_img_vsync; vs2 <= vs1;
      hs1 <= bus.pre_img_hsync; hs2 <= hs1;
      val1 <= bus.pre_img_valid;
    end
  end

  assign vs_rise    = vs1 & ~vs2;
  assign vs_fall    = ~vs1 & vs2;
  assign hs_fall    = ~hs1 & hs2;
  assign drain_zero = (drain_cnt == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: enable only gates entry to a frame, never aborts one
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sh_en) state_nxt = ARM;
      ARM:     if (!sh_en) state_nxt = IDLE;
               else if (vs_rise) state_nxt = RUN;
      RUN:     if (vs_fall) state_nxt = DRAIN;
      DRAIN:   if (drain_zero) state_nxt = sh_en ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM-derived strobes
  always_comb begin
    gate        = (state == RUN) || (state == DRAIN);
    frame_end   = (state == DRAIN) && drain_zero;
    commit      = (state == IDLE) || frame_end;
    frame_start = (state == ARM) && sh_en && vs_rise;
  end

  // Line accounting; a vsync drop mid-line closes the partial line
  always_comb begin
    col_eff   = (val1 && (col != '1)) ? col + 1'b1 : col;
    line_end  = (state == RUN) && (hs_fall || (vs_fall && hs1));
    line_cnt  = line_end && (col_eff != '0);
    width_bad = line_cnt && !first_line && (col_eff != ref_width);
  end

  // Column/row/reference-width working counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0; row <= '0; ref_width <= '0; first_line <= 1'b1;
    end else if (frame_start) begin
      col <= '0; row <= '0; ref_width <= '0; first_line <= 1'b1;
    end else if (state == RUN) begin
      if (line_end) begin
        col <= '0;
        if (line_cnt) begin
          if (row != '1) row <= row + 1'b1;
          if (first_line) begin
            ref_width  <= col_eff;
            first_line <= 1'b0;
          end
        end
      end else begin
        col <= col_eff;
      end
    end
  end

  // Drain countdown lets the datapath pipeline flush after vsync drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              drain_cnt <= '0;
    else if ((state == RUN) && vs_fall)   drain_cnt <= DW'(DRAIN_CYC - 1);
    else if ((state == DRAIN) && !drain_zero) drain_cnt <= drain_cnt - 1'b1;
  end

  // Shadow config and sticky error; a new mismatch beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_en <= 1'b0; sh_byp <= 1'b0; sh_coef <= COEF_W'(DEF_COEF); err_r <= 1'b0;
    end else begin
      if (bus.cfg_wr && (bus.cfg_addr == 2'd0)) begin
        sh_en  <= bus.cfg_wdata[0];
        sh_byp <= bus.cfg_wdata[1];
      end
      if (bus.cfg_wr && (bus.cfg_addr == 2'd1)) sh_coef <= bus.cfg_wdata;
      if (width_bad) err_r <= 1'b1;
      else if (bus.cfg_wr && (bus.cfg_addr == 2'd2) && bus.cfg_wdata[0]) err_r <= 1'b0;
    end
  end

  // Active config follows shadow only while idle or at frame close
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_r <= COEF_W'(DEF_COEF); byp_r <= 1'b0;
    end else if (commit) begin
      coef_r <= sh_coef; byp_r <= sh_byp;
    end
  end

  // Frame-close status: done pulse, geometry latch, frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r <= 1'b0; mw_r <= '0; mh_r <= '0; fcnt_r <= '0;
    end else begin
      done_r <= frame_end;
      if (frame_end) begin
        mw_r   <= ref_width;
        mh_r   <= row;
        fcnt_r <= fcnt_r + 16'd1;
      end
    end
  end

  assign bus.coef        = coef_r;
  assign bus.bypass      = byp_r;
  assign bus.img_gate    = gate;
  assign bus.frame_busy  = gate;
  assign bus.frame_done  = done_r;
  assign bus.meas_width  = mw_r;
  assign bus.meas_height = mh_r;
  assign bus.timing_err  = err_r;
  assign bus.frame_cnt   = fcnt_r;
endmodule

// File: tb/tb_region_bin_frame_ctrl.sv
// Directed bench for region_bin_frame_ctrl with hand-computed expectations.
module tb_region_bin_frame_ctrl;
  localparam int DEF = 603980;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;

  region_bin_frame_ctrl_if bif ();
  region_bin_frame_ctrl dut (.clk(clk), .rst(rst), .bus(bif.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [19:0] d);
    bif.cfg_wr = 1'b1; bif.cfg_addr = a; bif.cfg_wdata = d;
    tick();
    bif.cfg_wr = 1'b0;
  endtask

  task automatic line(input int w);
    bif.pre_img_hsync = 1'b1;
    tick();
    for (int i = 0; i < w; i++) begin
      bif.pre_img_valid = 1'b1;
      tick();
    end
    bif.pre_img_valid = 1'b0;
    bif.pre_img_hsync = 1'b0;
    tick(); tick();
  endtask

  task automatic frame_begin();
    bif.pre_img_vsync = 1'b1;
    tick(); tick();
  endtask

  // Drops vsync and waits for frame_done; lat counts edges after the first
  // edge that samples vsync low. coef_pre is coef just before the pulse.
  task automatic frame_end(output int lat, output logic [19:0] coef_pre);
    bif.pre_img_vsync = 1'b0;
    tick();
    lat = 0;
    coef_pre = bif.coef;
    while (!bif.frame_done && lat < 40) begin
      coef_pre = bif.coef;
      tick();
      lat++;
    end
    if (lat >= 40) chk("done_timeout", 32'(lat), 32'd9);
  endtask

  task automatic quiet(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bif.frame_done || bif.frame_busy) seen++;
    end
  endtask

  initial begin
    int lat;
    int seen;
    logic [19:0] cp;
    bif.pre_img_vsync = 0; bif.pre_img_hsync = 0; bif.pre_img_valid = 0;
    bif.cfg_wr = 0; bif.cfg_addr = 0; bif.cfg_wdata = 0;
    tick(); tick();
    chk("rst_coef", 32'(bif.coef), DEF);
    chk("rst_bypass", 32'(bif.bypass), 0);
    chk("rst_busy", 32'(bif.frame_busy), 0);
    chk("rst_done", 32'(bif.frame_done), 0);
    chk("rst_cnt", 32'(bif.frame_cnt), 0);
    chk("rst_meas", 32'({bif.meas_width, bif.meas_height}), 0);
    rst = 1'b0;
    tick();

    // 16x4 frame with coef written mid-RUN
    cfg_write(2'd0, 20'd1);
    tick(); tick();
    frame_begin();
    chk("run_gate", 32'(bif.img_gate), 1);
    cfg_write(2'd1, 20'd300000);
    for (int l = 0; l < 4; l++) line(16);
    chk("coef_hold_run", 32'(bif.coef), DEF);
    frame_end(lat, cp);
    exp_cnt++;
    chk("done_latency", 32'(lat), 9);
    chk("coef_pre_done", 32'(cp), DEF);
    chk("coef_at_done", 32'(bif.coef), 300000);
    chk("meas_w", 32'(bif.meas_width), 16);
    chk("meas_h", 32'(bif.meas_height), 4);
    chk("cnt1", 32'(bif.frame_cnt), 32'(exp_cnt));
    chk("err0", 32'(bif.timing_err), 0);
    tick();
    chk("done_oneshot", 32'(bif.frame_done), 0);

    // Idle write commits on the next cycle
    cfg_write(2'd0, 20'd0);
    tick(); tick();
    cfg_write(2'd1, 20'd12345);
    tick();
    chk("coef_idle", 32'(bif.coef), 12345);

    // Enable while a frame is already running: that frame is skipped
    frame_begin();
    line(8);
    cfg_write(2'd0, 20'd1);
    line(8);
    bif.pre_img_vsync = 1'b0;
    quiet(15, seen);
    chk("midframe_skip", 32'(seen), 0);
    chk("midframe_cnt", 32'(bif.frame_cnt), 32'(exp_cnt));
    frame_begin();
    line(16); line(16);
    frame_end(lat, cp);
    exp_cnt++;
    chk("next_frame_cnt", 32'(bif.frame_cnt), 32'(exp_cnt));
    chk("next_frame_h", 32'(bif.meas_height), 2);

    // Line widths 16,16,15,16
    frame_begin();
    line(16); line(16); line(15);
    chk("err_after_l3", 32'(bif.timing_err), 1);
    line(16);
    frame_end(lat, cp);
    exp_cnt++;
    chk("err_sticky", 32'(bif.timing_err), 1);
    chk("err_meas_w", 32'(bif.meas_width), 16);
    chk("err_meas_h", 32'(bif.meas_height), 4);
    cfg_write(2'd2, 20'd1);
    chk("err_clear", 32'(bif.timing_err), 0);

    // Bypass written mid-frame takes effect at frame close
    frame_begin();
    line(16);
    cfg_write(2'd0, 20'd3);
    chk("bypass_hold", 32'(bif.bypass), 0);
    line(16);
    frame_end(lat, cp);
    exp_cnt++;
    chk("bypass_commit", 32'(bif.bypass), 1);

    // Clear enable during RUN: frame completes, then FSM idles
    frame_begin();
    line(8);
    cfg_write(2'd0, 20'd0);
    line(8);
    frame_end(lat, cp);
    exp_cnt++;
    chk("noabort_lat", 32'(lat), 9);
    chk("noabort_cnt", 32'(bif.frame_cnt), 32'(exp_cnt));
    frame_begin();
    line(8);
    bif.pre_img_vsync = 1'b0;
    quiet(15, seen);
    chk("idle_ignores", 32'(seen), 0);
    chk("idle_cnt", 32'(bif.frame_cnt), 32'(exp_cnt));

    // Frame with zero valid lines still completes
    cfg_write(2'd0, 20'd1);
    tick(); tick();
    frame_begin();
    frame_end(lat, cp);
    exp_cnt++;
    chk("empty_lat", 32'(lat), 9);
    chk("empty_meas", 32'({bif.meas_width, bif.meas_height}), 0);
    chk("empty_cnt", 32'(bif.frame_cnt), 32'(exp_cnt));

    // vsync drops while hsync high: partial 5-pixel line counted
    frame_begin();
    line(16);
    bif.pre_img_hsync = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bif.pre_img_valid = 1'b1;
      tick();
    end
    bif.pre_img_valid = 1'b0;
    frame_end(lat, cp);
    bif.pre_img_hsync = 1'b0;
    exp_cnt++;
    chk("partial_h", 32'(bif.meas_height), 2);
    chk("partial_err", 32'(bif.timing_err), 1);
    chk("partial_cnt", 32'(bif.frame_cnt), 32'(exp_cnt));

    // Async reset mid-RUN
    tick(); tick();
    frame_begin();
    line(4);
    chk("pre_rst_busy", 32'(bif.frame_busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bif.frame_busy), 0);
    chk("arst_cnt", 32'(bif.frame_cnt), 0);
    chk("arst_coef", 32'(bif.coef), DEF);
    chk("arst_err", 32'(bif.timing_err), 0);
    chk("arst_meas", 32'({bif.meas_width, bif.meas_height}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/region_bin_frame_ctrl.md
Name: region_bin_frame_ctrl

Overview:
- Frame-level sequencer and configuration owner for the 5x5 local-mean binarization datapath.
- Watches the pixel stream timing (vsync/hsync/valid), and arms the datapath only on a clean frame start.
- Holds the threshold scale coefficient and bypass mode in shadow registers, committing them only at frame boundaries so no frame is processed with mixed settings.
- Measures frame geometry, flags line-length inconsistencies, and counts completed frames for software.

Parameters:
- CNT_W, 12, width of column/row counters and measured width/height.
- COEF_W, 20, width of threshold scale coefficient.
- DEF_COEF, 603980, reset coefficient (about 0.9/25 in Q24, i.e. threshold = 0.9 x local mean).
- DRAIN_CYC, 8, cycles held in DRAIN after frame end so the datapath pipeline flushes.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- pre_img_vsync  in  1  frame-active, high during frame.
- pre_img_hsync  in  1  line-active, high during line.
- pre_img_valid  in  1  pixel valid.
- cfg_wr  in  1  config write strobe, single cycle.
- cfg_addr  in  2  0=ctrl, 1=coef, 2=status clear.
- cfg_wdata  in  COEF_W  write data. ctrl uses bit0=enable, bit1=bypass. Status clear uses bit0.
- coef  out  COEF_W  active coefficient fed to the datapath multiplier.
- bypass  out  1  active bypass mode. When set, the datapath passes grey pixels through.
- img_gate  out  1  high in RUN and DRAIN; qualifies datapath outputs.
- frame_busy  out  1  high in RUN or DRAIN.
- frame_done  out  1  one-cycle pulse on DRAIN exit.
- meas_width  out  CNT_W  valid-pixel count of the first line of the last completed frame.
- meas_height  out  CNT_W  count of lines with at least 1 valid pixel in the last completed frame.
- timing_err  out  1  sticky line-width mismatch flag.
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0.

Behaviour:
- Reset (async, any state):
  - State IDLE; coef=DEF_COEF, bypass=0, img_gate=0, frame_busy=0, frame_done=0.
  - meas_width=0, meas_height=0, timing_err=0, frame_cnt=0.
  - Shadow enable=0, shadow bypass=0, shadow coef=DEF_COEF.
- Edge detection:
  - vs_rise/vs_fall and hs_fall come from a 1-cycle registered copy of the inputs.
  - Detection latency is 1 clk.
- Config writes:
  - addr0 and addr1 always update the shadow registers in the cycle after cfg_wr.
  - addr2 with bit0=1 clears timing_err. If a clear and a new mismatch occur in the same cycle, the set wins.
  - addr3 is ignored.
- Commit rule:
  - Active coef/bypass load from shadow in every IDLE cycle, and on the DRAIN->ARM/IDLE transition.
  - They never change in ARM, RUN or DRAIN otherwise.
- State machine:
  - IDLE: if shadow enable=1, go to ARM.
  - ARM: if shadow enable=0, go to IDLE. On vs_rise, go to RUN and clear the column/row/first-line working counters.
    - A frame already in progress when ARM is entered (vsync high) is skipped; a rising edge is required.
  - RUN: on vs_fall, go to DRAIN and load the drain counter with DRAIN_CYC-1.
    - Clearing enable in RUN does not abort; the current frame completes.
  - DRAIN: decrement each cycle. At 0:
    - pulse frame_done;
    - latch meas_width/meas_height;
    - increment frame_cnt;
    - commit shadow;
    - go to ARM if shadow enable=1, else IDLE.
    - A vs_rise during DRAIN is ignored; the frame is treated as starting mid-stream and skipped.
- Counting in RUN:
  - col increments on valid and saturates at all-ones.
  - On hs_fall with col>0:
    - row++ (saturating);
    - if this is the first line, store col as ref_width;
    - otherwise, if col != ref_width, set timing_err;
    - then col=0.
  - An hs_fall with col=0 does not count as a line.
- Frame-level checks:
  - A frame with zero valid lines still completes: meas_width=0, meas_height=0, frame_done pulses.
  - vs_fall while hsync is still high: the partial line is counted (same as an hs_fall) before the DRAIN transition.

Test Plan:
- Reset, then enable via addr0=1. Send a 16x4 frame (16 valid per line, 4 lines) -> ARM then RUN on vs_rise. frame_done pulses DRAIN_CYC+1 clk after vsync falls. meas_width=16, meas_height=4, frame_cnt=1, timing_err=0.
- Write coef=300000 during RUN -> coef output stays 603980 until the frame_done cycle, then reads 300000. A write in IDLE appears 1 cycle later.
- Enable while vsync is already high mid-frame -> no RUN for that frame and no frame_done. The next full frame is processed, so frame_cnt increments by exactly 1.
- Frame with line widths 16,16,15,16 -> timing_err=1 after the third line and stays set. An addr2 write with bit0=1 clears it to 0.
- Clear enable during RUN -> the frame completes with frame_done, the FSM goes to IDLE, and the next vs_rise is ignored. Assert rst mid-RUN -> all outputs return to reset values immediately.
- Run 65536 frames (or force the counter near 0xFFFF) -> frame_cnt wraps 0xFFFF->0x0000. bypass=1 written mid-frame -> takes effect only after frame_done.
